ram_vga_line_fetcher: RTL and testbench

//  Parametrised successor to the single-bit row fetcher: streams pixels from a line-organised

---
 rtl/ram_vga_line_fetcher_if.sv | 14 +
 rtl/ram_vga_line_fetcher.sv | 134 +++++++++++++
 tb/tb_ram_vga_line_fetcher.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_vga_line_fetcher_if.sv
// RAM read port of the VGA line fetcher: one request strobe, a held address,
// and a data word qualified by a valid pulse of arbitrary latency.
interface ram_vga_line_fetcher_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 320
);
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_address;
  logic [WORD_W-1:0] ram_data;
  logic              ram_valid;

  modport master (output ram_rd, ram_address, input ram_data, ram_valid);
  modport slave  (input ram_rd, ram_address, output ram_data, ram_valid);
endinterface

// File: rtl/ram_vga_line_fetcher.sv
// Streams pixels from a line-per-word framebuffer to VGA using ping-pong line
// buffers; the next source line is fetched during horizontal blanking.
module ram_vga_line_fetcher #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int SCALE_LOG2 = 1,
  parameter int BPP        = 1,
  parameter int WORD_W     = 320,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic [15:0]            vga_row,
  input  logic [15:0]            vga_col,
  ram_vga_line_fetcher_if.master ram,
  output logic [BPP-1:0]         vga_data,
  output logic                   underrun,
  input  logic                   underrun_clr
);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] front_q, front_d, back_q, back_d;
  logic [15:0]       front_tag_q, front_tag_d;
  logic [15:0]       back_tag_q, back_tag_d;
  logic [15:0]       req_tag_q, req_tag_d;
  logic              front_vld_q, front_vld_d;
  logic              back_rdy_q, back_rdy_d;
  logic              underrun_q, underrun_d;
  logic [BPP-1:0]    vga_data_q, vga_data_d;

  logic [15:0]       nxt, src_nxt, pix_idx;
  logic [IDX_W-1:0]  bit_sel;
  logic              start_fetch, swap, active;

  always_comb begin
    nxt         = (vga_row == 16'(V_TOTAL - 1)) ? 16'd0 : vga_row + 16'd1;
    src_nxt     = nxt >> SCALE_LOG2;
    swap        = (vga_col == 16'(H_TOTAL - 1));
    start_fetch = (vga_col == 16'(H_ACTIVE)) && (nxt < 16'(V_ACTIVE)) &&
                  (!front_vld_q || (src_nxt != front_tag_q));
    active      = (vga_col < 16'(H_ACTIVE)) && (vga_row < 16'(V_ACTIVE)) && front_vld_q;
    pix_idx     = vga_col >> SCALE_LOG2;
    // Off-screen columns are steered to index 0 so they never address past the buffer
    bit_sel     = active ? IDX_W'(pix_idx * 16'(BPP)) : '0;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_tag_d   = req_tag_q;
    back_d      = back_q;
    back_tag_d  = back_tag_q;
    back_rdy_d  = back_rdy_q;
    front_d     = front_q;
    front_tag_d = front_tag_q;
    front_vld_d = front_vld_q;
    underrun_d  = underrun_q & ~underrun_clr;

    case (state_q)
      S_IDLE: begin
        if (start_fetch) begin
          state_d   = S_REQ;
          addr_d    = ADDR_W'(BASE_ADDR) + ADDR_W'(src_nxt);
          req_tag_d = src_nxt;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (ram.ram_valid) begin
          back_d     = ram.ram_data;
          back_tag_d = req_tag_q;
          back_rdy_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fetch still in flight at the swap point blanks the next row; its data lands later
    if (swap) begin
      if (state_q != S_IDLE) begin
        underrun_d  = 1'b1;
        front_vld_d = 1'b0;
      end else if (back_rdy_q) begin
        front_d     = back_q;
        front_tag_d = back_tag_q;
        front_vld_d = 1'b1;
        back_rdy_d  = 1'b0;
      end
    end

    vga_data_d = active ? front_q[bit_sel +: BPP] : '0;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= ADDR_W'(BASE_ADDR);
      req_tag_q   <= '0;
      back_q      <= '0;
      back_tag_q  <= '0;
      back_rdy_q  <= 1'b0;
      front_q     <= '0;
      front_tag_q <= '0;
      front_vld_q <= 1'b0;
      underrun_q  <= 1'b0;
      vga_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_tag_q   <= req_tag_d;
      back_q      <= back_d;
      back_tag_q  <= back_tag_d;
      back_rdy_q  <= back_rdy_d;
      front_q     <= front_d;
      front_tag_q <= front_tag_d;
      front_vld_q <= front_vld_d;
      underrun_q  <= underrun_d;
      vga_data_q  <= vga_data_d;
    end
  end

  assign ram.ram_rd      = (state_q == S_REQ);
  assign ram.ram_address = addr_q;
  assign vga_data        = vga_data_q;
  assign underrun        = underrun_q;
endmodule

// File: tb/tb_ram_vga_line_fetcher.sv
// Directed bench for ram_vga_line_fetcher: default 1bpp/2x instance plus a
// 4bpp unscaled instance, each served by a small latency-programmable RAM model.
module tb_ram_vga_line_fetcher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] vga_row, vga_col;
  logic        underrun_clr;
  logic [0:0]  vga_data;
  logic        underrun;
  logic [3:0]  vga_data2;
  logic        underrun2;

  ram_vga_line_fetcher_if #(.ADDR_W(8), .WORD_W(320)) ram_if ();
  ram_vga_line_fetcher_if #(.ADDR_W(8), .WORD_W(320)) ram_if2 ();

  ram_vga_line_fetcher dut (
    .vga_clk(clk), .reset(reset), .vga_row(vga_row), .vga_col(vga_col),
    .ram(ram_if), .vga_data(vga_data), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  ram_vga_line_fetcher #(.H_ACTIVE(80), .SCALE_LOG2(0), .BPP(4), .WORD_W(320)) dut2 (
    .vga_clk(clk), .reset(reset), .vga_row(vga_row), .vga_col(vga_col),
    .ram(ram_if2), .vga_data(vga_data2), .underrun(underrun2), .underrun_clr(underrun_clr)
  );

  int checks = 0;
  int errors = 0;

  int         ram_delay = 1;
  bit         pend = 0, pend2 = 0;
  int         cnt = 0;
  logic [7:0] paddr = '0;
  int         rd_cnt = 0;
  bit         track = 0;
  int         exp_addr = 0;
  logic [7:0] pat_b = 8'h00;
  logic [319:0] word2;

  function automatic logic [319:0] word1(input logic [7:0] a);
    logic [7:0] b;
    b = a ^ 8'hA5;
    if (a == 8'd5) return {160{2'b01}};
    return {40{b}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive timing, then step both RAM models just after the edge
  task automatic cyc(input int r, input int c);
    vga_row = 16'(r);
    vga_col = 16'(c);
    @(posedge clk);
    #1;
    ram_if.ram_valid = 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        ram_if.ram_valid = 1'b1;
        ram_if.ram_data  = word1(paddr);
        pend = 0;
      end else cnt--;
    end
    if (ram_if.ram_rd) begin
      pend  = 1;
      paddr = ram_if.ram_address;
      cnt   = ram_delay;
      rd_cnt++;
      if (track) begin
        chk("rd_addr", 32'(ram_if.ram_address), 32'(exp_addr));
        exp_addr++;
      end
    end
    ram_if2.ram_valid = 1'b0;
    if (pend2) begin
      ram_if2.ram_valid = 1'b1;
      ram_if2.ram_data  = word2;
      pend2 = 0;
    end
    if (ram_if2.ram_rd) pend2 = 1;
  endtask

  task automatic row_short(input int r);
    for (int c = 638; c < 646; c++) cyc(r, c);
    for (int c = 797; c < 800; c++) cyc(r, c);
  endtask

  task automatic row_full(input int r, input int mode);
    for (int c = 0; c < 800; c++) begin
      cyc(r, c);
      case (mode)
        1: chk("line5_px", 32'(vga_data), (c < 640 && ((c >> 1) % 2 == 0)) ? 32'd1 : 32'd0);
        2: chk("blank_px", 32'(vga_data), 32'd0);
        3: chk("line_px", 32'(vga_data), (c < 640) ? 32'(pat_b[3'((c >> 1) % 8)]) : 32'd0);
        4: chk("bpp4_px", 32'(vga_data2), (c < 80) ? 32'((c * 7 + 3) % 16) : 32'd0);
        default: ;
      endcase
    end
  endtask

  initial begin
    for (int k = 0; k < 80; k++) word2[k*4 +: 4] = 4'((k * 7 + 3) % 16);
    reset = 1'b1;
    underrun_clr = 1'b0;
    vga_row = '0;
    vga_col = '0;
    ram_if.ram_valid  = 1'b0;
    ram_if.ram_data   = '0;
    ram_if2.ram_valid = 1'b0;
    ram_if2.ram_data  = '0;

    // Reset values
    cyc(0, 0);
    cyc(0, 1);
    chk("rst_rd", 32'(ram_if.ram_rd), 32'd0);
    chk("rst_addr", 32'(ram_if.ram_address), 32'd0);
    chk("rst_data", 32'(vga_data), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;

    // Full frame: fetches at rows 524,1,3,...,477 with addresses 0..239
    track = 1; exp_addr = 0; rd_cnt = 0;
    row_short(524);
    for (int r = 0; r < 524; r++) row_short(r);
    track = 0;
    chk("frame_rd_count", 32'(rd_cnt), 32'd240);
    chk("frame_underrun", 32'(underrun), 32'd0);

    // Line 5 alternating pattern on rows 10 and 11
    row_short(8);
    row_short(9);
    row_full(10, 1);
    row_full(11, 1);

    // Late fetch for rows 22/23: underrun at swap, row 22 blank, row 23 shows line 11
    row_short(19);
    row_short(20);
    ram_delay = 200;
    for (int c = 640; c < 799; c++) cyc(21, c);
    chk("underrun_before_swap", 32'(underrun), 32'd0);
    cyc(21, 799);
    chk("underrun_at_swap", 32'(underrun), 32'd1);
    ram_delay = 1;
    row_full(22, 2);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    pat_b = 8'hAE;
    row_full(23, 3);
    underrun_clr = 1'b1;
    cyc(24, 0);
    underrun_clr = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'd0);

    // Set and clear in the same cycle: set wins
    ram_delay = 200;
    for (int c = 640; c < 799; c++) cyc(25, c);
    chk("underrun_pre_set", 32'(underrun), 32'd0);
    underrun_clr = 1'b1;
    cyc(25, 799);
    underrun_clr = 1'b0;
    chk("underrun_set_over_clr", 32'(underrun), 32'd1);
    ram_delay = 1;
    for (int c = 0; c < 60; c++) cyc(26, c);
    underrun_clr = 1'b1;
    cyc(26, 60);
    underrun_clr = 1'b0;
    chk("underrun_clr2", 32'(underrun), 32'd0);

    // Reset while waiting for data; the late ram_valid must be ignored
    ram_delay = 4;
    cyc(27, 640);
    chk("rd_before_reset", 32'(ram_if.ram_rd), 32'd1);
    cyc(27, 641);
    reset = 1'b1;
    cyc(27, 642);
    reset = 1'b0;
    for (int c = 643; c < 647; c++) cyc(27, c);
    chk("post_rst_rd", 32'(ram_if.ram_rd), 32'd0);
    chk("post_rst_addr", 32'(ram_if.ram_address), 32'd0);
    chk("post_rst_data", 32'(vga_data), 32'd0);
    chk("post_rst_underrun", 32'(underrun), 32'd0);
    cyc(27, 799);
    track = 1; exp_addr = 14; rd_cnt = 0;
    row_full(28, 2);
    track = 0;
    chk("resume_rd_count", 32'(rd_cnt), 32'd1);
    pat_b = 8'hAB;
    row_full(29, 3);

    // 4bpp unscaled instance: nibble per column, blank outside the active area
    row_full(30, 0);
    row_full(31, 4);
    cyc(479, 5);
    chk("bpp4_last_row", 32'(vga_data2), 32'd6);
    cyc(479, 80);
    chk("bpp4_col80", 32'(vga_data2), 32'd0);
    cyc(500, 5);
    chk("bpp4_vblank", 32'(vga_data2), 32'd0);
    chk("bpp1_vblank", 32'(vga_data), 32'd0);
    chk("bpp4_underrun", 32'(underrun2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
